mmx_wb_stage: RTL and testbench
===============================

// Module: mmx_wb_stage
// PURPOSE
//  Execute->writeback stage for the MMX/ECX ALU result (64b result + dest info).
//  Buffers results in a small in-order FIFO with valid/ready handshakes on both sides.
//  Drives MMX register-file and ECX writeback ports.
//  Decouples execute from writeback stalls without a combinational ready path.
// PARAMETERS
//  DEPTH   2   FIFO entries; legal values 2 or 4.
//  DATA_W  64  MMX result width.
// PORTS
//  clk           in   1   clock; all state updates on rising edge
//  rst           in   1   synchronous reset, active-high
//  flush         in   1   discard all buffered, uncommitted results
//  ex_valid      in   1   execute presents a result this cycle
//  ex_ready      out  1   stage can accept a result this cycle
//  ex_res        in   64  ALU result; ECX value taken from [31:0]
//  ex_mm_we      in   1   result writes an MMX register
//  ex_mm_dst     in   3   destination MMX register index
//  ex_ecx_we     in   1   result writes ECX
//  wb_valid      out  1   head entry is presented to writeback
//  wb_ready      in   1   writeback consumes the head entry
//  wb_mm_we      out  1   head entry MMX write enable (gated by wb_valid)
//  wb_mm_idx     out  3   head entry MMX index
//  wb_mm_data    out  64  head entry result
//  wb_ecx_we     out  1   head entry ECX write enable (gated by wb_valid)
//  wb_ecx_data   out  32  head entry result[31:0]
//  fwd_idx1/2    in   3   execute operand MMX indices (fwd build only)
//  fwd_hit1/2    out  1   buffered write pending to that index (fwd build only)
//  fwd_data1/2   out  64  youngest matching pending data (fwd build only)
// BEHAVIOUR
//  - Reset: count=0, rd/wr ptr=0, all wb_* and fwd_* outputs 0. ex_ready=0 while rst=1, then 1.
//  - push = ex_valid & ex_ready & ~flush.
//  - pop = wb_valid & wb_ready.
//  - ex_ready = (count != DEPTH) & ~rst. Depends only on registered state, never on wb_ready.
//  - Full + pop in the same cycle: no push that cycle; ex_ready rises the next cycle.
//  - Empty: wb_valid=0, all wb_* outputs 0. No bypass from ex_* to wb_* in the same cycle.
//  - Latency: a pushed result appears at wb_* the cycle after push (minimum 1 cycle).
//  - Ordering: strict in-order.
//  - An entry with mm_we=0 and ecx_we=0 still occupies a slot and still retires through the handshake.
//  - wb_* outputs are stable while wb_valid=1 and wb_ready=0.
//  - Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
//  - Simultaneous push and pop when not full: count unchanged, both pointers advance.
//  - flush: next cycle count=0 and ptrs=0. A push in the flush cycle is dropped.
//    A pop in the flush cycle is still honoured (the head already committed).
//  - rst mid-operation: identical to flush, and ex_ready is held 0 during rst.
// CONFIGURATION
//  MMX_WB_FWD_EN defined:
//   - fwd_hitN=1 iff some valid entry has mm_we=1 and mm_dst==fwd_idxN.
//   - fwd_dataN = data of the youngest such entry; otherwise 0.
//   - Purely combinational from FIFO state; the entry being pushed this cycle is not visible.
//  MMX_WB_FWD_EN undefined:
//   - fwd_* ports are absent and no compare logic is built.
//   - Execute must interlock on pending MMX writes.
// STRUCTURE
//  - mmx_pkg: MMX_IDX_W=3, MMX_W=64, ECX_W=32, and entry struct {data, mm_we, mm_dst, ecx_we}.
//  - Sub-module mmx_wb_fifo: DEPTH-entry storage, ptrs/count, push/pop/flush.
//    It exports per-entry valid, dst and data vectors for the forwarding compare.
//  - Top level: handshake glue, output gating and the forwarding priority select.
// TESTING
//  - Reset: hold rst 2 cycles with ex_valid=1 -> ex_ready=0, wb_valid=0;
//    first push after rst falls -> wb_valid=1 the next cycle.
//  - Fill: wb_ready=0, push 0x1111..., 0x2222... (DEPTH=2) -> ex_ready=0 after the 2nd push;
//    a 3rd ex_valid is not accepted; wb_mm_data stays 0x1111...
//  - Full + pop: full, wb_ready=1, ex_valid=1 -> no push that cycle, count=1;
//    the next cycle push accepted; retire order 0x1111, 0x2222, new.
//  - ECX: push res=0x0000_0000_0000_0004, ecx_we=1, mm_we=0 -> wb_ecx_we=1, wb_ecx_data=0x4, wb_mm_we=0.
//  - Flush: 2 entries, flush=1 with wb_ready=1 and ex_valid=1 -> head retired, pushed entry dropped,
//    wb_valid=0 the next cycle.
//  - Forwarding (MMX_WB_FWD_EN): entries mm3<=0xA then mm3<=0xB, fwd_idx1=3, fwd_idx2=4
//    -> fwd_hit1=1, fwd_data1=0xB, fwd_hit2=0.

Source files
------------

// File: rtl/mmx_pkg.sv
// Shared widths and the buffered writeback entry layout for the MMX/ECX writeback path.
package mmx_pkg;

  localparam int MMX_IDX_W = 3;
  localparam int MMX_W     = 64;
  localparam int ECX_W     = 32;

  typedef struct packed {
    logic [MMX_W-1:0]     data;
    logic                 mm_we;
    logic [MMX_IDX_W-1:0] mm_dst;
    logic                 ecx_we;
  } wb_entry_t;

  localparam int ENTRY_W = $bits(wb_entry_t);

endpackage

// File: rtl/mmx_wb_fifo.sv
// In-order result buffer: DEPTH entries, natural-wrap pointers, push/pop/flush.
// Exposes per-entry state so the top level can build the forwarding compare.
module mmx_wb_fifo
  import mmx_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 push,
  input  logic                 pop,
  input  wb_entry_t            push_entry,
  output wb_entry_t            head,
  output logic [CNT_W-1:0]     count,
  output logic [PTR_W-1:0]     rd_ptr,
  output logic                 ent_valid [DEPTH],
  output logic                 ent_mm_we [DEPTH],
  output logic [MMX_IDX_W-1:0] ent_dst   [DEPTH],
  output logic [MMX_W-1:0]     ent_data  [DEPTH]
);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage needs no reset: nothing outside reads a slot unless it is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  assign head = mem[rd_ptr];

  // A slot is live when its distance from the read pointer is below count.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_valid[i] = ({1'b0, PTR_W'(i) - rd_ptr} < count);
      ent_mm_we[i] = mem[i].mm_we;
      ent_dst[i]   = mem[i].mm_dst;
      ent_data[i]  = mem[i].data;
    end
  end

endmodule

// File: rtl/mmx_wb_stage.sv
// Execute->writeback buffer stage driving the MMX register file and ECX writeback.
// Define MMX_WB_FWD_EN to build the fwd_* ports and pending-write forwarding compare.
module mmx_wb_stage
  import mmx_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
`ifdef MMX_WB_FWD_EN
  input  logic [MMX_IDX_W-1:0] fwd_idx1,
  input  logic [MMX_IDX_W-1:0] fwd_idx2,
  output logic                 fwd_hit1,
  output logic                 fwd_hit2,
  output logic [DATA_W-1:0]    fwd_data1,
  output logic [DATA_W-1:0]    fwd_data2,
`endif
  input  logic                 ex_valid,
  output logic                 ex_ready,
  input  logic [DATA_W-1:0]    ex_res,
  input  logic                 ex_mm_we,
  input  logic [MMX_IDX_W-1:0] ex_mm_dst,
  input  logic                 ex_ecx_we,
  output logic                 wb_valid,
  input  logic                 wb_ready,
  output logic                 wb_mm_we,
  output logic [MMX_IDX_W-1:0] wb_mm_idx,
  output logic [DATA_W-1:0]    wb_mm_data,
  output logic                 wb_ecx_we,
  output logic [ECX_W-1:0]     wb_ecx_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t            push_entry;
  wb_entry_t            head;
  logic [CNT_W-1:0]     count;
  logic [PTR_W-1:0]     rd_ptr;
  logic                 ent_valid [DEPTH];
  logic                 ent_mm_we [DEPTH];
  logic [MMX_IDX_W-1:0] ent_dst   [DEPTH];
  logic [MMX_W-1:0]     ent_data  [DEPTH];
  logic                 push;
  logic                 pop;

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
  // ex_ready comes only from registered count (and rst), never from wb_ready, so a
  // full buffer that retires this cycle accepts again only on the following cycle.
  // valid, once raised, holds its payload stable until the matching ready is seen.
  assign ex_ready = (count != CNT_W'(DEPTH)) && !rst;
  assign wb_valid = (count != '0);
  assign push     = ex_valid && ex_ready && !flush;
  assign pop      = wb_valid && wb_ready;

  assign push_entry = '{data: ex_res, mm_we: ex_mm_we, mm_dst: ex_mm_dst, ecx_we: ex_ecx_we};

  mmx_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .push       (push),
    .pop        (pop),
    .push_entry (push_entry),
    .head       (head),
    .count      (count),
    .rd_ptr     (rd_ptr),
    .ent_valid  (ent_valid),
    .ent_mm_we  (ent_mm_we),
    .ent_dst    (ent_dst),
    .ent_data   (ent_data)
  );

  // Every writeback field reads as zero while nothing is presented.
  assign wb_mm_we    = wb_valid && head.mm_we;
  assign wb_ecx_we   = wb_valid && head.ecx_we;
  assign wb_mm_idx   = wb_valid ? head.mm_dst : '0;
  assign wb_mm_data  = wb_valid ? head.data : '0;
  assign wb_ecx_data = wb_valid ? head.data[ECX_W-1:0] : '0;

`ifdef MMX_WB_FWD_EN
  // Walk entries oldest to youngest so the last match, the youngest, wins.
  always_comb begin
    logic [PTR_W-1:0] slot;
    fwd_hit1  = 1'b0;
    fwd_hit2  = 1'b0;
    fwd_data1 = '0;
    fwd_data2 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = rd_ptr + PTR_W'(k);
      if (ent_valid[slot] && ent_mm_we[slot] && (ent_dst[slot] == fwd_idx1)) begin
        fwd_hit1  = 1'b1;
        fwd_data1 = ent_data[slot];
      end
      if (ent_valid[slot] && ent_mm_we[slot] && (ent_dst[slot] == fwd_idx2)) begin
        fwd_hit2  = 1'b1;
        fwd_data2 = ent_data[slot];
      end
    end
  end
`endif

endmodule

// File: tb/tb_mmx_wb_stage.sv
// Directed + random scoreboard bench for mmx_wb_stage; fwd checks build when MMX_WB_FWD_EN is defined.
module tb_mmx_wb_stage;
  import mmx_pkg::*;

  localparam int DEPTH = 2;
  localparam int W     = ENTRY_W;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        ex_valid;
  logic        ex_ready;
  logic [63:0] ex_res;
  logic        ex_mm_we;
  logic [2:0]  ex_mm_dst;
  logic        ex_ecx_we;
  logic        wb_valid;
  logic        wb_ready;
  logic        wb_mm_we;
  logic [2:0]  wb_mm_idx;
  logic [63:0] wb_mm_data;
  logic        wb_ecx_we;
  logic [31:0] wb_ecx_data;
`ifdef MMX_WB_FWD_EN
  logic [2:0]  fwd_idx1;
  logic [2:0]  fwd_idx2;
  logic        fwd_hit1;
  logic        fwd_hit2;
  logic [63:0] fwd_data1;
  logic [63:0] fwd_data2;
`endif

  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  mmx_wb_stage #(.DEPTH(DEPTH), .DATA_W(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
`ifdef MMX_WB_FWD_EN
    .fwd_idx1    (fwd_idx1),
    .fwd_idx2    (fwd_idx2),
    .fwd_hit1    (fwd_hit1),
    .fwd_hit2    (fwd_hit2),
    .fwd_data1   (fwd_data1),
    .fwd_data2   (fwd_data2),
`endif
    .ex_valid    (ex_valid),
    .ex_ready    (ex_ready),
    .ex_res      (ex_res),
    .ex_mm_we    (ex_mm_we),
    .ex_mm_dst   (ex_mm_dst),
    .ex_ecx_we   (ex_ecx_we),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_mm_we    (wb_mm_we),
    .wb_mm_idx   (wb_mm_idx),
    .wb_mm_data  (wb_mm_data),
    .wb_ecx_we   (wb_ecx_we),
    .wb_ecx_data (wb_ecx_data)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare every DUT output against the scoreboard head / reference state.
  task automatic check_outputs();
    wb_entry_t e;
    logic      exp_rdy;
    exp_rdy = !rst && (exp_q.size() != DEPTH);
    chk("ex_ready", 64'(ex_ready), 64'(exp_rdy));
    if (exp_q.size() != 0) begin
      e = wb_entry_t'(exp_q[0]);
      chk("wb_valid",    64'(wb_valid),    64'd1);
      chk("wb_mm_we",    64'(wb_mm_we),    64'(e.mm_we));
      chk("wb_mm_idx",   64'(wb_mm_idx),   64'(e.mm_dst));
      chk("wb_mm_data",  wb_mm_data,       e.data);
      chk("wb_ecx_we",   64'(wb_ecx_we),   64'(e.ecx_we));
      chk("wb_ecx_data", 64'(wb_ecx_data), 64'(e.data[31:0]));
    end else begin
      chk("idle_valid",  64'(wb_valid),    64'd0);
      chk("idle_bus",    {wb_mm_data[63:32], wb_ecx_data} | 64'({wb_mm_we, wb_mm_idx, wb_ecx_we}), 64'd0);
    end
`ifdef MMX_WB_FWD_EN
    begin
      logic        h1 = 1'b0, h2 = 1'b0;
      logic [63:0] d1 = '0, d2 = '0;
      for (int i = 0; i < exp_q.size(); i++) begin
        e = wb_entry_t'(exp_q[i]);
        if (e.mm_we && e.mm_dst == fwd_idx1) begin h1 = 1'b1; d1 = e.data; end
        if (e.mm_we && e.mm_dst == fwd_idx2) begin h2 = 1'b1; d2 = e.data; end
      end
      chk("fwd_hit1",  64'(fwd_hit1), 64'(h1));
      chk("fwd_data1", fwd_data1,     d1);
      chk("fwd_hit2",  64'(fwd_hit2), 64'(h2));
      chk("fwd_data2", fwd_data2,     d2);
    end
`endif
  endtask

  // Driver: apply one cycle of inputs, check, update the reference, advance a clock.
  task automatic drive(input logic v, input logic [63:0] res, input logic mmwe,
                       input logic [2:0] dst, input logic ecxwe, input logic wbr,
                       input logic fl);
    logic accept, popv;
    ex_valid  = v;
    ex_res    = res;
    ex_mm_we  = mmwe;
    ex_mm_dst = dst;
    ex_ecx_we = ecxwe;
    wb_ready  = wbr;
    flush     = fl;
    #1;
    check_outputs();
    accept = v && !rst && (exp_q.size() != DEPTH) && !fl;
    popv   = !rst && (exp_q.size() != 0) && wbr;
    if (popv) void'(exp_q.pop_front());
    if (rst || fl) exp_q.delete();
    else if (accept) exp_q.push_back(W'({res, mmwe, dst, ecxwe}));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; wb_ready = 1'b0;
    ex_valid = 1'b1; ex_res = '0; ex_mm_we = 1'b0; ex_mm_dst = '0; ex_ecx_we = 1'b0;
`ifdef MMX_WB_FWD_EN
    fwd_idx1 = 3'd3; fwd_idx2 = 3'd4;
`endif
    @(posedge clk);
    #1;
    // reset held two cycles with ex_valid asserted
    drive(1, 64'hDEAD, 1, 3'd1, 0, 0, 0);
    drive(1, 64'hDEAD, 1, 3'd1, 0, 0, 0);
    rst = 1'b0;

    // first push, then it retires
    drive(1, 64'h0123_4567_89AB_CDEF, 1, 3'd1, 0, 0, 0);
    drive(0, 64'h0, 0, 3'd0, 0, 1, 0);
    drive(0, 64'h0, 0, 3'd0, 0, 1, 0);

    // fill, third offer refused, full + pop, then new push
    drive(1, 64'h1111_1111_1111_1111, 1, 3'd2, 0, 0, 0);
    drive(1, 64'h2222_2222_2222_2222, 1, 3'd5, 0, 0, 0);
    drive(1, 64'h3333_3333_3333_3333, 1, 3'd6, 0, 0, 0);
    drive(1, 64'h3333_3333_3333_3333, 1, 3'd6, 0, 1, 0);
    drive(1, 64'h3333_3333_3333_3333, 1, 3'd6, 0, 1, 0);
    drive(0, 64'h0, 0, 3'd0, 0, 1, 0);
    drive(0, 64'h0, 0, 3'd0, 0, 1, 0);

    // ECX-only entry, then an entry with no write enables
    drive(1, 64'h0000_0000_0000_0004, 0, 3'd0, 1, 0, 0);
    drive(1, 64'hFFFF_0000_FFFF_0000, 0, 3'd7, 0, 1, 0);
    drive(0, 64'h0, 0, 3'd0, 0, 1, 0);
    drive(0, 64'h0, 0, 3'd0, 0, 1, 0);

    // flush with two buffered: head retires, offered entry dropped
    drive(1, 64'hAAAA_0000_0000_0001, 1, 3'd1, 0, 0, 0);
    drive(1, 64'hAAAA_0000_0000_0002, 1, 3'd2, 1, 0, 0);
    drive(1, 64'hAAAA_0000_0000_0003, 1, 3'd3, 0, 1, 1);
    drive(0, 64'h0, 0, 3'd0, 0, 1, 0);

    // two pending writes to mm3: youngest must forward
    drive(1, 64'hA, 1, 3'd3, 0, 0, 0);
    drive(1, 64'hB, 1, 3'd3, 0, 0, 0);
    drive(0, 64'h0, 0, 3'd0, 0, 0, 0);
    drive(0, 64'h0, 0, 3'd0, 0, 1, 0);
    drive(0, 64'h0, 0, 3'd0, 0, 1, 0);

    // random traffic
    for (int n = 0; n < 300; n++) begin
`ifdef MMX_WB_FWD_EN
      fwd_idx1 = 3'($urandom_range(0, 7));
      fwd_idx2 = 3'($urandom_range(0, 7));
`endif
      drive(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 15) == 0));
    end

    // reset while holding entries
    drive(1, 64'h5555, 1, 3'd4, 0, 0, 0);
    drive(1, 64'h6666, 1, 3'd4, 0, 0, 0);
    rst = 1'b1;
    drive(1, 64'h7777, 1, 3'd4, 0, 1, 0);
    rst = 1'b0;
    drive(0, 64'h0, 0, 3'd0, 0, 1, 0);
    drive(1, 64'h8888, 1, 3'd0, 1, 1, 0);
    drive(0, 64'h0, 0, 3'd0, 0, 1, 0);
    drive(0, 64'h0, 0, 3'd0, 0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
